// File: rtl/nussinov_kernel.sv
// nussinov_kernel: one in-place Nussinov DP pass over an NxN signed score table held in an
// external dual-port word memory, driven by an ap_start/ap_done block-level handshake.
module nussinov_kernel #(
    parameter int N        = 64,
    parameter int LOG2N    = 6,
    parameter int ADDR_WID = 2 * LOG2N,
    parameter int DATA_WID = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic [ADDR_WID-1:0] table_r_address0,
    output logic                table_r_ce0,
    output logic                table_r_we0,
    output logic [DATA_WID-1:0] table_r_d0,
    input  logic [DATA_WID-1:0] table_r_q0,
    output logic [ADDR_WID-1:0] table_r_address1,
    output logic                table_r_ce1,
    output logic                table_r_we1,
    output logic [DATA_WID-1:0] table_r_d1,
    input  logic [DATA_WID-1:0] table_r_q1
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD2, S_KLOOP, S_STORE, S_NEXT, S_DONE
    } state_e;

    localparam logic [LOG2N-1:0] IDX_LAST  = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] IDX_FIRST = LOG2N'(N - 2);
    localparam logic [LOG2N-1:0] IDX_ONE   = LOG2N'(1);
    localparam logic [LOG2N-1:0] IDX_ZERO  = LOG2N'(0);

    function automatic logic [1:0] seq_of(input logic [1:0] idx_lo);
        return idx_lo + 2'd1;
    endfunction

    function automatic logic bases_pair(input logic [1:0] a, input logic [1:0] b);
        return (({1'b0, a} + {1'b0, b}) == 3'd3);
    endfunction

    function automatic logic signed [DATA_WID-1:0] smax(
        input logic signed [DATA_WID-1:0] a,
        input logic signed [DATA_WID-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    state_e                     state_q, state_d;
    logic [LOG2N-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [DATA_WID-1:0] v_q, v_d;
    logic                       ld2_pend_q, ld2_pend_d, k_pend_q, k_pend_d;
    logic                       done_q, done_d, idle_q, idle_d;
    logic [ADDR_WID-1:0]        addr0_q, addr0_d, addr1_q, addr1_d;
    logic                       ce0_q, ce0_d, we0_q, we0_d, ce1_q, ce1_d;
    logic [DATA_WID-1:0]        d0_q, d0_d;
    logic signed [DATA_WID-1:0] q0_s, q1_s, bonus_s;
    logic [LOG2N-1:0]           i_inc_s, j_dec_s, k_inc_s;

    assign q0_s    = $signed(table_r_q0);
    assign q1_s    = $signed(table_r_q1);
    // The diagonal pairing bonus only applies once the cell spans more than two positions.
    assign bonus_s = {{(DATA_WID-1){1'b0}},
                      (((i_q + IDX_ONE) < j_q) && bases_pair(seq_of(i_q[1:0]), seq_of(j_q[1:0])))};
    assign i_inc_s = i_d + IDX_ONE;
    assign j_dec_s = j_d - IDX_ONE;
    assign k_inc_s = k_d + IDX_ONE;

    // Sequencer: walks cells row-by-row from the bottom and folds read data into v.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        v_d        = v_q;
        ld2_pend_d = 1'b0;
        k_pend_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_LOAD;
                    i_d     = IDX_FIRST;
                    j_d     = IDX_LAST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:  state_d = S_LOAD2;
            S_LOAD2: begin
                v_d        = smax(q0_s, q1_s);
                k_d        = i_q + IDX_ONE;
                ld2_pend_d = 1'b1;
                state_d    = S_KLOOP;
            end
            S_KLOOP: begin
                // Data arriving now belongs to the read issued last cycle (LOAD2 pair or a k pair).
                if (ld2_pend_q) begin
                    v_d = smax(smax(v_q, q0_s), q1_s + bonus_s);
                end else if (k_pend_q) begin
                    v_d = smax(v_q, q0_s + q1_s);
                end else begin
                    v_d = v_q;
                end
                if (k_q < j_q) begin
                    k_d      = k_q + IDX_ONE;
                    k_pend_d = 1'b1;
                    state_d  = S_KLOOP;
                end else begin
                    state_d = S_STORE;
                end
            end
            S_STORE: state_d = S_NEXT;
            S_NEXT: begin
                if (j_q != IDX_LAST) begin
                    j_d     = j_q + IDX_ONE;
                    state_d = S_LOAD;
                end else if (i_q == IDX_ZERO) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q - IDX_ONE;
                    j_d     = i_q;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port and handshake outputs are decoded from the next state so they leave flops.
    always_comb begin
        addr0_d = {ADDR_WID{1'b0}};
        addr1_d = {ADDR_WID{1'b0}};
        ce0_d   = 1'b0;
        we0_d   = 1'b0;
        ce1_d   = 1'b0;
        d0_d    = {DATA_WID{1'b0}};
        case (state_d)
            S_LOAD: begin
                ce0_d   = 1'b1;
                ce1_d   = 1'b1;
                addr0_d = {i_d, j_d};
                addr1_d = {i_d, j_dec_s};
            end
            S_LOAD2: begin
                ce0_d   = 1'b1;
                ce1_d   = 1'b1;
                addr0_d = {i_inc_s, j_d};
                addr1_d = {i_inc_s, j_dec_s};
            end
            S_KLOOP: begin
                if (k_d < j_d) begin
                    ce0_d   = 1'b1;
                    ce1_d   = 1'b1;
                    addr0_d = {i_d, k_d};
                    addr1_d = {k_inc_s, j_d};
                end else begin
                    ce0_d = 1'b0;
                    ce1_d = 1'b0;
                end
            end
            S_STORE: begin
                ce0_d   = 1'b1;
                we0_d   = 1'b1;
                addr0_d = {i_d, j_d};
                d0_d    = v_d;
            end
            default: ce0_d = 1'b0;
        endcase
        idle_d = (state_d == S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset that aborts any pass in flight.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            i_q        <= IDX_ZERO;
            j_q        <= IDX_ZERO;
            k_q        <= IDX_ZERO;
            v_q        <= {DATA_WID{1'b0}};
            ld2_pend_q <= 1'b0;
            k_pend_q   <= 1'b0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
            addr0_q    <= {ADDR_WID{1'b0}};
            addr1_q    <= {ADDR_WID{1'b0}};
            ce0_q      <= 1'b0;
            we0_q      <= 1'b0;
            ce1_q      <= 1'b0;
            d0_q       <= {DATA_WID{1'b0}};
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            v_q        <= v_d;
            ld2_pend_q <= ld2_pend_d;
            k_pend_q   <= k_pend_d;
            done_q     <= done_d;
            idle_q     <= idle_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            ce0_q      <= ce0_d;
            we0_q      <= we0_d;
            ce1_q      <= ce1_d;
            d0_q       <= d0_d;
        end
    end

    assign ap_done          = done_q;
    assign ap_ready         = done_q;
    assign ap_idle          = idle_q;
    assign table_r_address0 = addr0_q;
    assign table_r_ce0      = ce0_q;
    assign table_r_we0      = we0_q;
    assign table_r_d0       = d0_q;
    assign table_r_address1 = addr1_q;
    assign table_r_ce1      = ce1_q;
    assign table_r_we1      = 1'b0;
    assign table_r_d1       = {DATA_WID{1'b0}};

endmodule

// File: tb/tb_nussinov_kernel.sv
// Bench for nussinov_kernel: a full-size (64) instance for one pass and a 16x16 instance for
// the remaining randomized passes, both against a loop-level reference of the DP recurrence.
module tb_nussinov_kernel;
    localparam int NA = 16;
    localparam int NB = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b;
    logic        a_done, a_idle, a_ready, a_ce0, a_we0, a_ce1, a_we1;
    logic [7:0]  a_addr0, a_addr1;
    logic [31:0] a_d0, a_d1, a_q0, a_q1;
    logic        b_done, b_idle, b_ready, b_ce0, b_we0, b_ce1, b_we1;
    logic [11:0] b_addr0, b_addr1;
    logic [31:0] b_d0, b_d1, b_q0, b_q1;
    logic        hwa_we, hwb_we;
    logic [11:0] hw_addr;
    logic [31:0] hw_data;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [4096];
    int          mdl   [4096];
    int          init  [4096];
    int          n_cmp = 0;
    int          n_err = 0;

    nussinov_kernel #(.N(NA), .LOG2N(4)) dut_a (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .ap_done(a_done), .ap_idle(a_idle),
        .ap_ready(a_ready), .table_r_address0(a_addr0), .table_r_ce0(a_ce0),
        .table_r_we0(a_we0), .table_r_d0(a_d0), .table_r_q0(a_q0),
        .table_r_address1(a_addr1), .table_r_ce1(a_ce1), .table_r_we1(a_we1),
        .table_r_d1(a_d1), .table_r_q1(a_q1)
    );

    nussinov_kernel dut_b (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .ap_done(b_done), .ap_idle(b_idle),
        .ap_ready(b_ready), .table_r_address0(b_addr0), .table_r_ce0(b_ce0),
        .table_r_we0(b_we0), .table_r_d0(b_d0), .table_r_q0(b_q0),
        .table_r_address1(b_addr1), .table_r_ce1(b_ce1), .table_r_we1(b_we1),
        .table_r_d1(b_d1), .table_r_q1(b_q1)
    );

    // Dual-port synchronous memories; the host port preloads while the kernel is idle.
    always @(posedge clk) begin
        if (hwa_we) mem_a[hw_addr[7:0]] <= hw_data;
        else if (a_ce0 && a_we0) mem_a[a_addr0] <= a_d0;
        if (a_ce0 && !a_we0) a_q0 <= mem_a[a_addr0];
        if (a_ce1) a_q1 <= mem_a[a_addr1];
    end

    always @(posedge clk) begin
        if (hwb_we) mem_b[hw_addr] <= hw_data;
        else if (b_ce0 && b_we0) mem_b[b_addr0] <= b_d0;
        if (b_ce0 && !b_we0) b_q0 <= mem_b[b_addr0];
        if (b_ce1) b_q1 <= mem_b[b_addr1];
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Straight transcription of the recurrence on a row-major n x n table.
    task automatic ref_pass(input int n);
        for (int i = n - 1; i >= 0; i--) begin
            for (int j = i + 1; j < n; j++) begin
                int v;
                int m;
                m = ((i < j - 1) && ((((i + 1) % 4) + ((j + 1) % 4)) == 3)) ? 1 : 0;
                v = mdl[i*n + j];
                v = imax(v, mdl[i*n + j - 1]);
                v = imax(v, mdl[(i+1)*n + j]);
                v = imax(v, mdl[(i+1)*n + j - 1] + m);
                for (int k = i + 1; k < j; k++) v = imax(v, mdl[i*n + k] + mdl[(k+1)*n + j]);
                mdl[i*n + j] = v;
            end
        end
    endtask

    function automatic logic [31:0] rd(input bit use_b, input int a);
        return use_b ? mem_b[a] : mem_a[a[7:0]];
    endfunction

    task automatic load_mem(input bit use_b, input int n);
        for (int a = 0; a < n * n; a++) begin
            @(negedge clk);
            hwa_we  = !use_b;
            hwb_we  = use_b;
            hw_addr = 12'(a);
            hw_data = 32'(init[a]);
            mdl[a]  = init[a];
        end
        @(negedge clk);
        hwa_we = 1'b0;
        hwb_we = 1'b0;
    endtask

    task automatic cmp_table(input bit use_b, input int n, input string tag);
        int bad = 0;
        for (int a = 0; a < n * n; a++) if (rd(use_b, a) !== 32'(mdl[a])) bad++;
        chk_eq(tag, 32'(bad), 32'd0);
    endtask

    // One pass with bounded wait; poke=1 keeps re-asserting start at random while busy.
    task automatic run_pass(input bit use_b, input bit poke, output int ndone);
        int  budget;
        bit  finished;
        budget   = use_b ? 60000 : 3000;
        ndone    = 0;
        finished = 1'b0;
        @(negedge clk);
        chk_eq("idle_before_start", 32'(use_b ? b_idle : a_idle), 32'd1);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk_eq("idle_drop_after_start", 32'(use_b ? b_idle : a_idle), 32'd0);
        for (int c = 0; c < budget; c++) begin
            start_a = !use_b && poke && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (use_b ? b_done : a_done) begin
                ndone++;
                chk_eq("ready_with_done", 32'(use_b ? b_ready : a_ready), 32'd1);
            end
            if (use_b ? b_idle : a_idle) begin
                finished = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
        if (!finished) chk_eq("pass_timeout", 32'd0, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (use_b ? b_done : a_done) ndone++;
        end
    endtask

    initial begin
        int nd;
        int found;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        hwa_we = 1'b0; hwb_we = 1'b0; hw_addr = 12'd0; hw_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_a_idle", 32'(a_idle), 32'd1);
        chk_eq("rst_a_done", 32'(a_done | a_ready), 32'd0);
        chk_eq("rst_a_ce", 32'(a_ce0 | a_ce1 | a_we0), 32'd0);
        chk_eq("rst_b_idle", 32'(b_idle), 32'd1);
        chk_eq("rst_b_ce", 32'(b_ce0 | b_ce1 | b_we0 | b_done), 32'd0);
        chk_eq("we1_const", 32'(a_we1 | b_we1), 32'd0);

        // Full-size table: zeros with a single seed below the diagonal.
        for (int a = 0; a < NB * NB; a++) init[a] = 0;
        init[63*NB + 62] = 100;
        load_mem(1'b1, NB);
        ref_pass(NB);
        run_pass(1'b1, 1'b0, nd);
        chk_eq("b_single_done", 32'(nd), 32'd1);
        chk_eq("b_t62_63", mem_b[62*NB + 63], 32'd100);
        found = 0;
        for (int i = 0; i < NB; i++)
            for (int j = 0; j <= i; j++) if (mem_b[i*NB + j] !== 32'(init[i*NB + j])) found++;
        chk_eq("b_lower_unchanged", 32'(found), 32'd0);
        cmp_table(1'b1, NB, "b_table_seeded");

        // All -5.
        for (int a = 0; a < NA * NA; a++) init[a] = -5;
        load_mem(1'b0, NA);
        ref_pass(NA);
        run_pass(1'b0, 1'b0, nd);
        chk_eq("a_t14_15_neg", mem_a[14*NA + 15], -32'sd5);
        chk_eq("a_t0_15_neg", mem_a[15], 32'(mdl[15]));
        cmp_table(1'b0, NA, "a_table_neg5");

        // All zeros: cell (0,5) must pick up the seq0/seq5 pairing.
        for (int a = 0; a < NA * NA; a++) init[a] = 0;
        load_mem(1'b0, NA);
        ref_pass(NA);
        run_pass(1'b0, 1'b0, nd);
        chk_eq("a_t0_5_ge1", 32'($signed(mem_a[5]) >= 1), 32'd1);
        cmp_table(1'b0, NA, "a_table_zero");

        // Abort during the k loop, then a clean pass on fresh random data.
        for (int a = 0; a < NA * NA; a++) init[a] = int'($urandom_range(0, 20)) - 10;
        load_mem(1'b0, NA);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat ($urandom_range(0, 300)) @(negedge clk);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (a_ce1 && (a_addr1[7:4] != a_addr0[7:4])) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk_eq("a_kloop_reached", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("abort_ce", 32'(a_ce0 | a_ce1 | a_we0), 32'd0);
        chk_eq("abort_idle", 32'(a_idle), 32'd1);
        rst = 1'b0;
        for (int a = 0; a < NA * NA; a++) init[a] = int'($urandom_range(0, 20)) - 10;
        load_mem(1'b0, NA);
        ref_pass(NA);
        run_pass(1'b0, 1'b0, nd);
        chk_eq("a_after_abort_done", 32'(nd), 32'd1);
        cmp_table(1'b0, NA, "a_table_after_abort");

        // Starts while busy are ignored; two back-to-back passes compose.
        for (int a = 0; a < NA * NA; a++) init[a] = int'($urandom_range(0, 6)) - 3;
        load_mem(1'b0, NA);
        ref_pass(NA);
        ref_pass(NA);
        run_pass(1'b0, 1'b1, nd);
        chk_eq("a_busy_start_single_done", 32'(nd), 32'd1);
        run_pass(1'b0, 1'b0, nd);
        cmp_table(1'b0, NA, "a_table_two_passes");

        // Full-range words exercise signed compare and wrapping adds.
        for (int a = 0; a < NA * NA; a++) init[a] = int'($urandom());
        load_mem(1'b0, NA);
        ref_pass(NA);
        run_pass(1'b0, 1'b0, nd);
        cmp_table(1'b0, NA, "a_table_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
